// File: rtl/frame_burst_writer_pkg.sv
// Shared memory-controller definitions: burst writer FSM encoding and the
// default maximum burst length.
// Ports: none (package only).
package frame_burst_writer_pkg;

  localparam int FBW_BURST_LEN_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    BURST     = 2'd2,
    NEXT      = 2'd3
  } fbw_state_t;

endpackage

// File: rtl/frame_burst_writer.sv
// Purpose: splits a frame (base, length in words) into write bursts of at most BURST_LEN words fed from a show-ahead FIFO.
// Latency: burst request one cycle after the FIFO holds a full burst; frame_done two cycles after the last burst's finish.
// Backpressure: waits in WAIT_DATA until fifo_count covers the next burst; pops only on data_req, capped at the burst length.
// Ports:
//   mem_clk, rst_n                    clock, async active-low reset
//   frame_start, base_addr, frame_len frame command (pulse + operands)
//   fifo_count, fifo_q, fifo_rd_en    show-ahead source FIFO
//   wr_burst_*                        burst write master interface
//   busy, frame_done                  frame status
module frame_burst_writer
  import frame_burst_writer_pkg::*;
#(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 24,
  parameter int BURST_LEN     = FBW_BURST_LEN_DEFAULT
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic [ADDR_BITS-1:0]     base_addr,
  input  logic [ADDR_BITS-1:0]     frame_len,
  input  logic [10:0]              fifo_count,
  input  logic [MEM_DATA_BITS-1:0] fifo_q,
  output logic                     fifo_rd_en,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     busy,
  output logic                     frame_done
);

  fbw_state_t           state, state_nxt;
  logic [ADDR_BITS-1:0] addr, remaining;
  logic [ADDR_BITS-1:0] pend_base, pend_len;
  logic                 pend_vld;
  logic [9:0]           beat_cnt;
  logic [9:0]           cur_len;
  logic                 frame_done_r;
  logic                 rem_ge_burst;
  logic                 take_new, take_pend;
  logic                 beat_ok;

  // cur_len = min(BURST_LEN, remaining); BURST_LEN <= 1023 so 10 bits suffice.
  assign rem_ge_burst = (remaining >= ADDR_BITS'(BURST_LEN));
  assign cur_len      = rem_ge_burst ? 10'(BURST_LEN) : remaining[9:0];

  // Beats past the burst length still arrive from the master but must not pop.
  assign beat_ok   = wr_burst_data_req && (beat_cnt < cur_len);

  // A fresh pulse in IDLE wins over a stale pending command.
  assign take_new  = (state == IDLE) && frame_start;
  assign take_pend = (state == IDLE) && !frame_start && pend_vld;

  // State register
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_done_r <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done_r <= (state == WAIT_DATA) && (remaining == '0);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (frame_start || pend_vld) state_nxt = WAIT_DATA;
      WAIT_DATA: begin
        if (remaining == '0)                    state_nxt = IDLE;
        else if ({1'b0, cur_len} <= fifo_count) state_nxt = BURST;
      end
      BURST:     if (wr_burst_finish) state_nxt = NEXT;
      NEXT:      state_nxt = WAIT_DATA;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    wr_burst_req = (state == BURST);
    fifo_rd_en   = (state == BURST) && beat_ok;
    busy         = (state != IDLE);
  end

  // addr/remaining only move in IDLE and NEXT, so len/addr stay stable while requesting.
  assign wr_burst_len  = cur_len;
  assign wr_burst_addr = addr;
  assign wr_burst_data = fifo_q;
  assign frame_done    = frame_done_r;

  // Frame datapath: address/remaining, pending command, beat counter
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      pend_vld  <= 1'b0;
      pend_base <= '0;
      pend_len  <= '0;
      beat_cnt  <= '0;
    end else begin
      if (take_new) begin
        addr      <= base_addr;
        remaining <= frame_len;
      end else if (take_pend) begin
        addr      <= pend_base;
        remaining <= pend_len;
      end else if (state == NEXT) begin
        // Wraps modulo 2^ADDR_BITS; cur_len <= remaining so no underflow.
        addr      <= addr + ADDR_BITS'(cur_len);
        remaining <= remaining - ADDR_BITS'(cur_len);
      end

      // Pulses while busy are held; a later pulse overwrites the earlier one.
      if (frame_start && (state != IDLE)) begin
        pend_vld  <= 1'b1;
        pend_base <= base_addr;
        pend_len  <= frame_len;
      end else if (take_new || take_pend) begin
        pend_vld  <= 1'b0;
      end

      if (state == BURST) begin
        if (beat_ok) beat_cnt <= beat_cnt + 10'd1;
      end else begin
        beat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_burst_writer.sv
module tb_frame_burst_writer;
  localparam int DW = 64;
  localparam int AW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          frame_start;
  logic [AW-1:0] base_addr, frame_len;
  logic [10:0]   fifo_count;
  logic [DW-1:0] fifo_q;

  logic          rd0, req0, dreq0, fin0, busy0, done0;
  logic [9:0]    blen0;
  logic [AW-1:0] baddr0;
  logic [DW-1:0] bdata0;
  logic          rd1, req1, dreq1, fin1, busy1, done1;
  logic [9:0]    blen1;
  logic [AW-1:0] baddr1;
  logic [DW-1:0] bdata1;

  frame_burst_writer #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) dut0 (
    .mem_clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .base_addr(base_addr), .frame_len(frame_len),
    .fifo_count(fifo_count), .fifo_q(fifo_q), .fifo_rd_en(rd0),
    .wr_burst_req(req0), .wr_burst_len(blen0), .wr_burst_addr(baddr0),
    .wr_burst_data_req(dreq0), .wr_burst_data(bdata0),
    .wr_burst_finish(fin0), .busy(busy0), .frame_done(done0));

  frame_burst_writer #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_LEN(64)) dut1 (
    .mem_clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .base_addr(base_addr), .frame_len(frame_len),
    .fifo_count(fifo_count), .fifo_q(fifo_q), .fifo_rd_en(rd1),
    .wr_burst_req(req1), .wr_burst_len(blen1), .wr_burst_addr(baddr1),
    .wr_burst_data_req(dreq1), .wr_burst_data(bdata1),
    .wr_burst_finish(fin1), .busy(busy1), .frame_done(done1));

  // Event counters, written only here.
  int pops0 = 0, dones0 = 0, pops1 = 0, dones1 = 0;
  always @(negedge clk) begin
    if (rd0)   pops0  = pops0 + 1;
    if (done0) dones0 = dones0 + 1;
    if (rd1)   pops1  = pops1 + 1;
    if (done1) dones1 = dones1 + 1;
  end

  // Memory-side responders: log each burst, issue len+2 data requests
  // (two surplus beats), then a one-cycle finish.
  int            n0 = 0, n1 = 0;
  logic [9:0]    log_len0 [16];
  logic [AW-1:0] log_addr0 [16];
  logic [9:0]    log_len1 [16];
  logic [AW-1:0] log_addr1 [16];

  initial begin : resp0
    int bl;
    dreq0 = 1'b0; fin0 = 1'b0;
    forever begin
      @(negedge clk);
      if (req0) begin
        log_len0[n0 % 16] = blen0; log_addr0[n0 % 16] = baddr0; n0 = n0 + 1;
        bl = int'(blen0) + 2;
        @(posedge clk); #1 dreq0 = 1'b1;
        repeat (bl) @(posedge clk);
        #1 dreq0 = 1'b0; fin0 = 1'b1;
        @(posedge clk); #1 fin0 = 1'b0;
      end
    end
  end

  initial begin : resp1
    int bl;
    dreq1 = 1'b0; fin1 = 1'b0;
    forever begin
      @(negedge clk);
      if (req1) begin
        log_len1[n1 % 16] = blen1; log_addr1[n1 % 16] = baddr1; n1 = n1 + 1;
        bl = int'(blen1) + 2;
        @(posedge clk); #1 dreq1 = 1'b1;
        repeat (bl) @(posedge clk);
        #1 dreq1 = 1'b0; fin1 = 1'b1;
        @(posedge clk); #1 fin1 = 1'b0;
      end
    end
  end

  int nvec = 0, nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec = nvec + 1;
    if (act !== exp) begin
      nfail = nfail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(posedge clk); #1;
    frame_start = 1'b1; base_addr = b; frame_len = l;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 4000 && (busy0 || busy1); i++) @(negedge clk);
    chk(name, {62'd0, busy0, busy1}, 64'd0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic [10:0]   fifo;
    int            nb;
    int            l_first;
    logic [AW-1:0] a_first;
    int            l_last;
    logic [AW-1:0] a_last;
    int            pops;
  } vec_t;

  vec_t tbl [6];

  initial begin : main
    int s, s1, p, d, li;
    tbl[0] = '{24'h000100, 24'd256, 11'd300, 2, 128, 24'h000100, 128, 24'h000180, 256};
    tbl[1] = '{24'h001000, 24'd200, 11'd300, 2, 128, 24'h001000,  72, 24'h001080, 200};
    tbl[2] = '{24'h000000, 24'd1,   11'd300, 1,   1, 24'h000000,   1, 24'h000000,   1};
    tbl[3] = '{24'h000050, 24'd128, 11'd128, 1, 128, 24'h000050, 128, 24'h000050, 128};
    tbl[4] = '{24'hFFFF80, 24'd256, 11'd300, 2, 128, 24'hFFFF80, 128, 24'h000000, 256};
    tbl[5] = '{24'h123456, 24'd129, 11'd300, 2, 128, 24'h123456,   1, 24'h1234D6, 129};

    rst_n = 1'b0; frame_start = 1'b0; base_addr = '0; frame_len = '0;
    fifo_count = 11'd300; fifo_q = 64'hDEAD_BEEF_0123_4567;

    // Reset state
    @(negedge clk);
    chk("rst_req",  {63'd0, req0},  64'd0);
    chk("rst_len",  {54'd0, blen0}, 64'd0);
    chk("rst_addr", {40'd0, baddr0}, 64'd0);
    chk("rst_rd",   {63'd0, rd0},   64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_done", {63'd0, done0}, 64'd0);
    chk("data_pass_a", bdata0, 64'hDEAD_BEEF_0123_4567);
    fifo_q = 64'h0F0F_1234_A5A5_0001;
    #1 chk("data_pass_b", bdata0, 64'h0F0F_1234_A5A5_0001);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length frame: frame_done two cycles after the pulse, no burst
    s = n0; d = dones0;
    pulse(24'h000123, 24'd0);
    @(negedge clk);
    chk("zl_busy",   {63'd0, busy0}, 64'd1);
    chk("zl_done_1", {63'd0, done0}, 64'd0);
    @(negedge clk);
    chk("zl_done_2", {63'd0, done0}, 64'd1);
    chk("zl_idle",   {63'd0, busy0}, 64'd0);
    @(negedge clk);
    chk("zl_done_3", {63'd0, done0}, 64'd0);
    chk("zl_nburst", 64'(n0 - s), 64'd0);
    wait_idle("zl_timeout");
    chk("zl_ndone",  64'(dones0 - d), 64'd1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      fifo_count = tbl[i].fifo;
      s = n0; p = pops0; d = dones0;
      pulse(tbl[i].base, tbl[i].len);
      wait_idle($sformatf("v%0d_timeout", i));
      li = (s + tbl[i].nb - 1) % 16;
      chk($sformatf("v%0d_nburst", i),  64'(n0 - s), 64'(tbl[i].nb));
      chk($sformatf("v%0d_len0", i),    64'(log_len0[s % 16]), 64'(tbl[i].l_first));
      chk($sformatf("v%0d_addr0", i),   64'(log_addr0[s % 16]), 64'(tbl[i].a_first));
      chk($sformatf("v%0d_lenN", i),    64'(log_len0[li]), 64'(tbl[i].l_last));
      chk($sformatf("v%0d_addrN", i),   64'(log_addr0[li]), 64'(tbl[i].a_last));
      chk($sformatf("v%0d_pops", i),    64'(pops0 - p), 64'(tbl[i].pops));
      chk($sformatf("v%0d_ndone", i),   64'(dones0 - d), 64'd1);
    end
    fifo_count = 11'd300;

    // FIFO underfilled: no request until it holds a full burst
    fifo_count = 11'd100; s = n0;
    pulse(24'h000800, 24'd128);
    repeat (20) @(negedge clk);
    chk("uf_noreq",  {63'd0, req0}, 64'd0);
    chk("uf_nburst", 64'(n0 - s), 64'd0);
    chk("uf_busy",   {63'd0, busy0}, 64'd1);
    fifo_count = 11'd128;
    @(negedge clk);
    chk("uf_req",  {63'd0, req0}, 64'd1);
    chk("uf_len",  64'(blen0), 64'd128);
    chk("uf_addr", 64'(baddr0), 64'h000800);
    fifo_q = 64'h5555_AAAA_0000_FFFF;
    #1 chk("uf_data", bdata0, 64'h5555_AAAA_0000_FFFF);
    wait_idle("uf_timeout");
    fifo_count = 11'd300;

    // Short tail burst waits for its own (smaller) fill level
    fifo_count = 11'd128; s = n0;
    pulse(24'h004000, 24'd200);
    for (int i = 0; i < 200 && !req0; i++) @(negedge clk);
    chk("tail_req1", {63'd0, req0}, 64'd1);
    fifo_count = 11'd71;
    for (int i = 0; i < 500 && req0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("tail_wait71", {63'd0, req0}, 64'd0);
    chk("tail_busy",   {63'd0, busy0}, 64'd1);
    fifo_count = 11'd72;
    @(negedge clk);
    chk("tail_req2", {63'd0, req0}, 64'd1);
    wait_idle("tail_timeout");
    chk("tail_len",  64'(log_len0[(s + 1) % 16]), 64'd72);
    chk("tail_addr", 64'(log_addr0[(s + 1) % 16]), 64'h004080);
    fifo_count = 11'd300;

    // Address wrap with BURST_LEN=64
    s1 = n1;
    pulse(24'hFFFFC0, 24'd128);
    wait_idle("wrap_timeout");
    chk("wrap_nburst", 64'(n1 - s1), 64'd2);
    chk("wrap_addr0",  64'(log_addr1[s1 % 16]), 64'hFFFFC0);
    chk("wrap_addr1",  64'(log_addr1[(s1 + 1) % 16]), 64'h000000);
    chk("wrap_len1",   64'(log_len1[(s1 + 1) % 16]), 64'd64);

    // Pending frame: two pulses during a burst, the later one wins
    s = n0; p = pops0; d = dones0;
    pulse(24'h000100, 24'd128);
    for (int i = 0; i < 200 && !req0; i++) @(negedge clk);
    chk("pend_req", {63'd0, req0}, 64'd1);
    pulse(24'h250000, 24'd16);
    pulse(24'h200000, 24'd64);
    for (int i = 0; i < 3000 && (dones0 - d) < 2; i++) @(negedge clk);
    wait_idle("pend_timeout");
    chk("pend_ndone",  64'(dones0 - d), 64'd2);
    chk("pend_nburst", 64'(n0 - s), 64'd2);
    chk("pend_addr",   64'(log_addr0[(s + 1) % 16]), 64'h200000);
    chk("pend_len",    64'(log_len0[(s + 1) % 16]), 64'd64);
    chk("pend_pops",   64'(pops0 - p), 64'd192);

    // Reset during a burst; stray data_req/finish afterwards are ignored
    pulse(24'h000400, 24'd128);
    for (int i = 0; i < 200 && !req0; i++) @(negedge clk);
    chk("mr_req", {63'd0, req0}, 64'd1);
    repeat (5) @(negedge clk);
    s = n0; d = dones0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("mr_req0",  {63'd0, req0},  64'd0);
    chk("mr_len0",  {54'd0, blen0}, 64'd0);
    chk("mr_addr0", {40'd0, baddr0}, 64'd0);
    chk("mr_rd0",   {63'd0, rd0},   64'd0);
    chk("mr_busy0", {63'd0, busy0}, 64'd0);
    chk("mr_done0", {63'd0, done0}, 64'd0);
    repeat (3) @(negedge clk);
    p = pops0;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("mr_nodone", 64'(dones0 - d), 64'd0);
    chk("mr_idle",   {63'd0, busy0}, 64'd0);
    chk("mr_nopop",  64'(pops0 - p), 64'd0);
    chk("mr_noburst", 64'(n0 - s), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/frame_burst_writer.md
FRAME_BURST_WRITER -- requirements
Module: frame_burst_writer

Interface
REQ-001 Parameters SHALL be MEM_DATA_BITS, default 64, width of one burst data word.
REQ-002 Parameters SHALL be ADDR_BITS, default 24, width of burst word address.
REQ-003 Parameters SHALL be BURST_LEN, default 128, maximum words per burst (legal range 1..1023).
REQ-004 Ports SHALL be, clock and reset first: mem_clk in 1 sole clock; rst_n in 1 reset (one clock; reset is asynchronous and active-low).
REQ-005 Ports SHALL be frame_start in 1 single-cycle pulse, begin frame; base_addr in ADDR_BITS frame base word address; frame_len in ADDR_BITS frame length in words.
REQ-006 Ports SHALL be fifo_count in 11 words held in show-ahead source FIFO; fifo_q in MEM_DATA_BITS FIFO head word; fifo_rd_en out 1 FIFO pop.
REQ-007 Ports SHALL be wr_burst_req out 1; wr_burst_len out 10; wr_burst_addr out ADDR_BITS; wr_burst_data_req in 1; wr_burst_data out MEM_DATA_BITS; wr_burst_finish in 1.
REQ-008 Ports SHALL be busy out 1 frame in progress; frame_done out 1 single-cycle pulse at frame end.

Function
REQ-009 FSM states SHALL be IDLE, WAIT_DATA, BURST, NEXT; encoding unconstrained.
REQ-010 IDLE: on frame_start, latch base_addr into addr register and frame_len into remaining register, go to WAIT_DATA next cycle.
REQ-011 Current length cur_len SHALL equal min(BURST_LEN, remaining), computed from registered remaining.
REQ-012 WAIT_DATA: when remaining = 0, pulse frame_done one cycle and go to IDLE; else when fifo_count >= cur_len, go to BURST.
REQ-013 On BURST entry wr_burst_req SHALL rise; wr_burst_len = cur_len and wr_burst_addr = addr, both stable while wr_burst_req is high.
REQ-014 wr_burst_req SHALL stay high until and including the cycle wr_burst_finish is sampled high, then drop.
REQ-015 fifo_rd_en SHALL equal wr_burst_data_req combinationally while in BURST, 0 otherwise; wr_burst_data SHALL equal fifo_q combinationally.
REQ-016 A beat counter SHALL count wr_burst_data_req cycles within BURST; data_req beyond cur_len beats SHALL NOT pop the FIFO.
REQ-017 On wr_burst_finish in BURST go to NEXT; NEXT SHALL add cur_len to addr, subtract cur_len from remaining, then go to WAIT_DATA.
REQ-018 Address arithmetic SHALL be modulo 2^ADDR_BITS (wrap silently); remaining never underflows since cur_len <= remaining.
REQ-019 frame_len = 0 SHALL produce frame_done two cycles after frame_start with no burst issued.
REQ-020 frame_start outside IDLE SHALL be latched as pending (base/len captured at pulse time); current frame completes, frame_done pulses, then the pending frame starts from IDLE next cycle without a new pulse.
REQ-021 A second frame_start while one is already pending SHALL overwrite the pending base/len.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 wr_burst_finish or wr_burst_data_req outside BURST SHALL be ignored.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, clear pending flag, addr, remaining, beat counter.
REQ-025 Reset values: wr_burst_req 0, wr_burst_len 0, wr_burst_addr 0, fifo_rd_en 0, busy 0, frame_done 0.
REQ-026 Reset mid-burst SHALL abandon the burst immediately; recovery of the downstream arbiter is the system's responsibility.

Structure
REQ-027 FSM state encoding and BURST_LEN default SHALL live in the shared memory-controller package; no other typedefs.
REQ-028 Single module, no sub-modules; min() and address adder inline.

Verification
REQ-029 base=0x000100, len=256, fifo_count=300 -> two bursts: len 128 addr 0x000100, len 128 addr 0x000180; frame_done once; 256 pops.
REQ-030 len=200 -> bursts of 128 then 72 at base+128; second waits until fifo_count >= 72.
REQ-031 fifo_count held at 100, len=128 -> no wr_burst_req until fifo_count reaches 128, then request within 1 cycle.
REQ-032 base=0xFFFFC0, len=128, BURST_LEN=64 -> second burst addr 0x000000.
REQ-033 frame_start during first burst with base=0x200000 -> first frame finishes, frame_done, then new frame starts at 0x200000 without a further pulse.
REQ-034 rst_n low while wr_burst_req high -> all outputs 0 in the same cycle, busy 0, no frame_done.
